// File: rtl/sram_rr_arb_pkg.sv
// sram_arb_pkg: shared types for the SRAM round-robin arbiter.
//   arb_state_e - arbiter FSM state encoding
//   REQ_IDX_W   - width of a requester index (covers up to 4 requesters)
package sram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RD_WAIT = 2'd2
  } arb_state_e;

  localparam int REQ_IDX_W = 2;

endpackage

// File: rtl/sram_rr_arb_if.sv
// sram_rr_arb_if: bus bundle between NUM_REQ requesters, the arbiter and the
// downstream SRAM controller.
//   requester side : req_address/byteenable/read/write/writedata/lock in,
//                    req_waitrequest/readdata/readdataready out
//   downstream side: address/byteenable/read/write/writedata out,
//                    waitrequest/readdata/readdataready in
// modport master: the arbiter view; modport slave: the environment view.
interface sram_rr_arb_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16
);
  localparam int BE_W = DATA_WIDTH / 8;

  logic [NUM_REQ*ADDR_WIDTH-1:0] req_address;
  logic [NUM_REQ*BE_W-1:0]       req_byteenable;
  logic [NUM_REQ-1:0]            req_read;
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_writedata;
  logic [NUM_REQ-1:0]            req_lock;
  logic [NUM_REQ-1:0]            req_waitrequest;
  logic [DATA_WIDTH-1:0]         req_readdata;
  logic [NUM_REQ-1:0]            req_readdataready;

  logic [ADDR_WIDTH-1:0]         address;
  logic [BE_W-1:0]               byteenable;
  logic                          read;
  logic                          write;
  logic [DATA_WIDTH-1:0]         writedata;
  logic                          waitrequest;
  logic [DATA_WIDTH-1:0]         readdata;
  logic                          readdataready;

  modport master (
    input  req_address, req_byteenable, req_read, req_write, req_writedata, req_lock,
    output req_waitrequest, req_readdata, req_readdataready,
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdataready
  );

  modport slave (
    output req_address, req_byteenable, req_read, req_write, req_writedata, req_lock,
    input  req_waitrequest, req_readdata, req_readdataready,
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdataready
  );

endinterface

// File: rtl/sram_rr_arb_rr_pick.sv
// rr_pick: combinational round-robin priority selector.
//   req_i - request vector
//   ptr_i - index with highest priority this round
//   gnt_o - one-hot grant (zero when nothing requests)
//   idx_o - index of the granted requester
module rr_pick
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [REQ_IDX_W-1:0] ptr_i,
  output logic [NUM_REQ-1:0]   gnt_o,
  output logic [REQ_IDX_W-1:0] idx_o
);

  logic found;

  // Scan offsets 0..NUM_REQ-1 from the pointer; first hit wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req_i[i] && (((int'(ptr_i) + off) % NUM_REQ) == i)) begin
          found    = 1'b1;
          gnt_o[i] = 1'b1;
          idx_o    = REQ_IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/sram_rr_arb.sv
// sram_rr_arb: round-robin arbiter multiplexing NUM_REQ requesters onto one
// SRAM command port, with optional per-requester grant locking.
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   bus            : sram_rr_arb_if master modport (requester + downstream)
//   grant_count    : per-requester 16-bit saturating accept counters,
//                    present only when SRAM_ARB_STATS_EN is defined
module sram_rr_arb
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_LOCK   = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
`ifdef SRAM_ARB_STATS_EN
  output logic [NUM_REQ*16-1:0] grant_count,
`endif
  sram_rr_arb_if.master         bus
);

  localparam int BE_W   = DATA_WIDTH / 8;
  localparam int LOCK_W = $clog2(MAX_LOCK + 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(MAX_LOCK - 1);

  arb_state_e           state_q, state_d;
  logic [REQ_IDX_W-1:0] owner_q, owner_d;
  logic [REQ_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [LOCK_W-1:0]    lock_cnt_q, lock_cnt_d;

  logic [NUM_REQ-1:0]   req_any;
  logic [NUM_REQ-1:0]   pick_gnt;
  logic [REQ_IDX_W-1:0] pick_idx;

  logic                  own_rd, own_wr, own_lock;
  logic [ADDR_WIDTH-1:0] own_addr;
  logic [BE_W-1:0]       own_be;
  logic [DATA_WIDTH-1:0] own_wdata;
  logic                  release_req;

  function automatic logic [REQ_IDX_W-1:0] next_idx(input logic [REQ_IDX_W-1:0] cur);
    if (cur == REQ_IDX_W'(NUM_REQ - 1)) return '0;
    return cur + 1'b1;
  endfunction

  assign req_any = bus.req_read | bus.req_write;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i (req_any),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  // Owner's command fields; read wins when both strobes are set.
  always_comb begin
    own_rd    = 1'b0;
    own_wr    = 1'b0;
    own_lock  = 1'b0;
    own_addr  = '0;
    own_be    = '0;
    own_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == REQ_IDX_W'(i)) begin
        own_rd    = bus.req_read[i];
        own_wr    = bus.req_write[i] & ~bus.req_read[i];
        own_lock  = bus.req_lock[i];
        own_addr  = bus.req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
        own_be    = bus.req_byteenable[i*BE_W +: BE_W];
        own_wdata = bus.req_writedata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    lock_cnt_d  = lock_cnt_q;
    release_req = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|pick_gnt) begin
          owner_d = pick_idx;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (own_rd && !bus.waitrequest)      state_d = ST_RD_WAIT;
        else if (own_wr && !bus.waitrequest) release_req = 1'b1;
        // An idle unlocked owner gives up the grant.
        else if (!own_rd && !own_wr && !own_lock) release_req = 1'b1;
      end
      ST_RD_WAIT: begin
        if (bus.readdataready) release_req = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    // Locked owner keeps the grant for at most MAX_LOCK transactions.
    if (release_req) begin
      if (own_lock && (lock_cnt_q < LOCK_LAST)) begin
        state_d    = ST_GRANT;
        lock_cnt_d = lock_cnt_q + 1'b1;
      end else begin
        state_d    = ST_IDLE;
        rr_ptr_d   = next_idx(owner_q);
        lock_cnt_d = '0;
      end
    end
  end

  always_comb begin
    bus.address           = '0;
    bus.byteenable        = '0;
    bus.writedata         = '0;
    bus.read              = 1'b0;
    bus.write             = 1'b0;
    bus.req_waitrequest   = '1;
    bus.req_readdataready = '0;
    bus.req_readdata      = bus.readdata;
    if (state_q == ST_GRANT) begin
      bus.address    = own_addr;
      bus.byteenable = own_be;
      bus.writedata  = own_wdata;
      bus.read       = own_rd;
      bus.write      = own_wr;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == REQ_IDX_W'(i)) begin
        if (state_q == ST_GRANT) bus.req_waitrequest[i] = bus.waitrequest;
        if (state_q == ST_RD_WAIT && bus.readdataready) bus.req_readdataready[i] = 1'b1;
      end
    end
  end

`ifdef SRAM_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] cnt_q;
  logic                     accept;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign accept = (state_q == ST_GRANT) && (own_rd || own_wr) && !bus.waitrequest;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (accept) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (owner_q == REQ_IDX_W'(i)) cnt_q[i] <= sat_inc16(cnt_q[i]);
      end
    end
  end

  assign grant_count = cnt_q;
`endif

endmodule

// File: tb/tb_sram_rr_arb.sv
// tb_sram_rr_arb: directed table-driven bench for sram_rr_arb (NUM_REQ=2).
// Requester 0 uses address 0x00010 / data 0xBEEF, requester 1 uses
// address 0x00200 / data 0x1234. Optional stats check under SRAM_ARB_STATS_EN.
module tb_sram_rr_arb;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  sram_rr_arb_if #(.NUM_REQ(2), .ADDR_WIDTH(20), .DATA_WIDTH(16)) bus ();

`ifdef SRAM_ARB_STATS_EN
  logic [31:0] grant_count;
`endif

  sram_rr_arb #(.NUM_REQ(2), .ADDR_WIDTH(20), .DATA_WIDTH(16), .MAX_LOCK(8)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
`ifdef SRAM_ARB_STATS_EN
    .grant_count (grant_count),
`endif
    .bus         (bus)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  rd, wr, lk;
    logic        wt, rdy;
    logic [15:0] rdata;
    logic        e_rd, e_wr;
    logic [1:0]  e_wreq, e_rrdy;
    logic [19:0] e_addr;
    logic [15:0] e_rdat;
  } vec_t;

  vec_t tbl[$];
  int total = 0;
  int bad = 0;

  function automatic vec_t mk(logic rst, logic [1:0] rd, logic [1:0] wr, logic [1:0] lk,
                              logic wt, logic rdy, logic [15:0] rdata,
                              logic e_rd, logic e_wr, logic [1:0] e_wreq, logic [1:0] e_rrdy,
                              logic [19:0] e_addr, logic [15:0] e_rdat);
    vec_t v;
    v.rst = rst; v.rd = rd; v.wr = wr; v.lk = lk; v.wt = wt; v.rdy = rdy; v.rdata = rdata;
    v.e_rd = e_rd; v.e_wr = e_wr; v.e_wreq = e_wreq; v.e_rrdy = e_rrdy;
    v.e_addr = e_addr; v.e_rdat = e_rdat;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.req_read      = '0;
    bus.req_write     = '0;
    bus.req_lock      = '0;
    bus.waitrequest   = 1'b0;
    bus.readdataready = 1'b0;
    bus.readdata      = '0;
  endtask

  // Ends on a falling edge with reset released and inputs idle.
  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    clear_inputs();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  int n1;
  logic seen0;

  initial begin
    bus.req_address    = {20'h00200, 20'h00010};
    bus.req_writedata  = {16'h1234, 16'hBEEF};
    bus.req_byteenable = 4'b1111;
    clear_inputs();
    bus.req_read = 2'b11;

    // Reset state, with requests present.
    #3;
    chk("rst_read", {31'd0, bus.read}, 32'd0);
    chk("rst_write", {31'd0, bus.write}, 32'd0);
    chk("rst_addr", {12'd0, bus.address}, 32'd0);
    chk("rst_be", {30'd0, bus.byteenable}, 32'd0);
    chk("rst_wdata", {16'd0, bus.writedata}, 32'd0);
    chk("rst_wreq", {30'd0, bus.req_waitrequest}, 32'd3);
    chk("rst_rrdy", {30'd0, bus.req_readdataready}, 32'd0);

    //          rst rd     wr     lk     wt rdy rdata     e_rd e_wr wreq   rrdy   addr       rdat
    // Single write from requester 0 with two wait cycles.
    tbl.push_back(mk(1, 2'b00, 2'b01, 2'b00, 1, 0, 16'h0,    0, 0, 2'b11, 2'b00, 20'h0,     16'h0));
    tbl.push_back(mk(0, 2'b00, 2'b01, 2'b00, 1, 0, 16'h0,    0, 1, 2'b11, 2'b00, 20'h00010, 16'h0));
    tbl.push_back(mk(0, 2'b00, 2'b01, 2'b00, 1, 0, 16'h0,    0, 1, 2'b11, 2'b00, 20'h00010, 16'h0));
    tbl.push_back(mk(0, 2'b00, 2'b01, 2'b00, 0, 0, 16'h0,    0, 1, 2'b10, 2'b00, 20'h00010, 16'h0));
    tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 0, 0, 16'h0,    0, 0, 2'b11, 2'b00, 20'h0,     16'h0));
    // Two simultaneous reads: 0 first, then 1; spurious readdataready in IDLE last.
    tbl.push_back(mk(1, 2'b11, 2'b00, 2'b00, 0, 0, 16'h0,    0, 0, 2'b11, 2'b00, 20'h0,     16'h0));
    tbl.push_back(mk(0, 2'b11, 2'b00, 2'b00, 0, 0, 16'h0,    1, 0, 2'b10, 2'b00, 20'h00010, 16'h0));
    tbl.push_back(mk(0, 2'b10, 2'b00, 2'b00, 0, 0, 16'h0,    0, 0, 2'b11, 2'b00, 20'h0,     16'h0));
    tbl.push_back(mk(0, 2'b10, 2'b00, 2'b00, 0, 1, 16'hAAAA, 0, 0, 2'b11, 2'b01, 20'h0,     16'hAAAA));
    tbl.push_back(mk(0, 2'b10, 2'b00, 2'b00, 0, 0, 16'h0,    0, 0, 2'b11, 2'b00, 20'h0,     16'h0));
    tbl.push_back(mk(0, 2'b10, 2'b00, 2'b00, 0, 0, 16'h0,    1, 0, 2'b01, 2'b00, 20'h00200, 16'h0));
    tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 0, 1, 16'h5555, 0, 0, 2'b11, 2'b10, 20'h0,     16'h5555));
    tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 0, 1, 16'h7777, 0, 0, 2'b11, 2'b00, 20'h0,     16'h0));
    // Read+write together -> read; owner idles unlocked -> grant rotates to 1.
    tbl.push_back(mk(1, 2'b01, 2'b01, 2'b00, 1, 0, 16'h0,    0, 0, 2'b11, 2'b00, 20'h0,     16'h0));
    tbl.push_back(mk(0, 2'b01, 2'b01, 2'b00, 1, 0, 16'h0,    1, 0, 2'b11, 2'b00, 20'h00010, 16'h0));
    tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 1, 0, 16'h0,    0, 0, 2'b11, 2'b00, 20'h00010, 16'h0));
    tbl.push_back(mk(0, 2'b11, 2'b00, 2'b00, 0, 0, 16'h0,    0, 0, 2'b11, 2'b00, 20'h0,     16'h0));
    tbl.push_back(mk(0, 2'b11, 2'b00, 2'b00, 0, 0, 16'h0,    1, 0, 2'b01, 2'b00, 20'h00200, 16'h0));
    tbl.push_back(mk(0, 2'b01, 2'b00, 2'b00, 0, 1, 16'h0F0F, 0, 0, 2'b11, 2'b10, 20'h0,     16'h0F0F));

    foreach (tbl[r]) begin
      if (tbl[r].rst) do_reset();
      else @(negedge clock);
      bus.req_read      = tbl[r].rd;
      bus.req_write     = tbl[r].wr;
      bus.req_lock      = tbl[r].lk;
      bus.waitrequest   = tbl[r].wt;
      bus.readdataready = tbl[r].rdy;
      bus.readdata      = tbl[r].rdata;
      #1;
      chk($sformatf("row%0d_read", r), {31'd0, bus.read}, {31'd0, tbl[r].e_rd});
      chk($sformatf("row%0d_write", r), {31'd0, bus.write}, {31'd0, tbl[r].e_wr});
      chk($sformatf("row%0d_wreq", r), {30'd0, bus.req_waitrequest}, {30'd0, tbl[r].e_wreq});
      chk($sformatf("row%0d_rrdy", r), {30'd0, bus.req_readdataready}, {30'd0, tbl[r].e_rrdy});
      chk($sformatf("row%0d_addr", r), {12'd0, bus.address}, {12'd0, tbl[r].e_addr});
      if (tbl[r].e_wr)
        chk($sformatf("row%0d_wdata", r), {16'd0, bus.writedata},
            (tbl[r].e_addr == 20'h00010) ? 32'hBEEF : 32'h1234);
      if (tbl[r].e_rrdy != 2'b00)
        chk($sformatf("row%0d_rdata", r), {16'd0, bus.req_readdata}, {16'd0, tbl[r].e_rdat});
    end

    // Locked requester 1 streams writes while 0 waits: 8 writes, then 0.
    do_reset();
    bus.req_write = 2'b10;
    bus.req_lock  = 2'b10;
    n1 = 0;
    seen0 = 1'b0;
    for (int c = 0; c < 40 && !seen0; c++) begin
      if (c > 0) begin
        @(negedge clock);
        bus.req_write = 2'b11;
      end
      #1;
      if (bus.write && !bus.req_waitrequest[1]) n1++;
      if (bus.write && !bus.req_waitrequest[0]) seen0 = 1'b1;
    end
    chk("lock_writes_from_1", n1, 32'd8);
    chk("lock_then_0_granted", {31'd0, seen0}, 32'd1);

    // Reset pulsed while a read is outstanding.
    do_reset();
    bus.req_read = 2'b01;
    @(negedge clock); #1;
    chk("rdw_grant_read", {31'd0, bus.read}, 32'd1);
    @(negedge clock);
    bus.req_read = 2'b00;
    #1;
    chk("rdw_wait_wreq", {30'd0, bus.req_waitrequest}, 32'd3);
    reset_n = 1'b0;
    bus.readdataready = 1'b1;
    bus.readdata = 16'hDEAD;
    #1;
    chk("rdw_rst_read", {31'd0, bus.read}, 32'd0);
    chk("rdw_rst_addr", {12'd0, bus.address}, 32'd0);
    chk("rdw_rst_wreq", {30'd0, bus.req_waitrequest}, 32'd3);
    chk("rdw_rst_rrdy", {30'd0, bus.req_readdataready}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("rdw_late_rrdy0", {30'd0, bus.req_readdataready}, 32'd0);
    @(negedge clock); #1;
    chk("rdw_late_rrdy1", {30'd0, bus.req_readdataready}, 32'd0);
    bus.readdataready = 1'b0;

`ifdef SRAM_ARB_STATS_EN
    // Three accepted writes from requester 0.
    do_reset();
    bus.req_write = 2'b01;
    repeat (6) @(negedge clock);
    bus.req_write = 2'b00;
    @(negedge clock); #1;
    chk("stats_req0", {16'd0, grant_count[15:0]}, 32'd3);
    chk("stats_req1", {16'd0, grant_count[31:16]}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
